pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
- Parametrised N-lane inter-stage pipeline register for the multi-issue core: ID/EX, EX/MEM and MEM/WB instantiate it with per-lane packed payloads.
- Adds the following to a plain two-lane latch:
  - per-lane valid bits
  - per-lane kill with optional younger-lane squash
  - selectable payload clearing on bubbles
  - hold/bubble status
- Sits between two pipeline stages. It is driven by the central stall controller and the exception/flush unit.

Parameters:
- LANES, 2, number of issue lanes (1..4); lane 0 is oldest.
- WIDTH, 128, payload bits per lane.
- CLEAR_DATA, 1, 1 = zero the payload of invalid/bubbled/killed lanes; 0 = leave payload bits unchanged, only valid cleared.
- KILL_YOUNGER, 1, 1 = kill_mask[i] also squashes all lanes j>i; 0 = kill affects lane i only.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- stall_up  in  1  producing stage stalled.
- stall_down  in  1  consuming stage stalled.
- flush  in  1  pipeline flush (exception/eret).
- kill_mask  in  LANES  per-lane squash of the incoming bundle.
- in_valid  in  LANES  incoming lane valids.
- in_data  in  LANES*WIDTH  incoming payloads; lane i at [i*WIDTH +: WIDTH].
- out_valid  out  LANES  registered lane valids.
- out_data  out  LANES*WIDTH  registered payloads.
- out_bubble  out  1  registered; 1 when the current contents are an inserted bubble (stall_up & ~stall_down).
- out_held  out  1  registered; 1 when the last edge was a hold.
- stat_bubbles  out  32  bubble-insert count (see Optional Feature).
- stat_holds  out  32  hold-cycle count (see Optional Feature).

Behaviour:
- Reset is rst, synchronous, active-high, on clock clk. All register updates occur on the rising edge of clk.
- Reset values: out_valid=0, out_data=0, out_bubble=0, out_held=0, stat_*=0.
- The edge action is chosen by this priority:
  1. rst | flush:
     - out_valid=0, out_bubble=0, out_held=0.
     - out_data=0 if CLEAR_DATA, else unchanged.
     - flush does not clear stat_*.
  2. stall_down (regardless of stall_up):
     - Hold: out_valid and out_data unchanged, out_held=1, out_bubble unchanged.
  3. stall_up & ~stall_down:
     - Bubble: out_valid=0, out_bubble=1, out_held=0.
     - out_data=0 if CLEAR_DATA, else unchanged.
  4. Otherwise:
     - Capture: out_bubble=0, out_held=0.
     - Per lane: killed[i] = KILL_YOUNGER ? |kill_mask[i:0] : kill_mask[i].
     - out_valid[i] = in_valid[i] & ~killed[i].
     - out_data lane i = in_data lane i if out_valid[i] next, else 0 if CLEAR_DATA, else in_data lane i.
- Latency: exactly one cycle from input to output on capture. There is no combinational path from any input to any output.
- Holding across multiple cycles keeps contents stable indefinitely. Release follows the normal capture rule on the first non-stall edge.
- Flush during hold: flush wins, and contents are cleared on that edge.
- kill_mask is ignored on hold, bubble and flush edges.
- LANES=1: younger-lane squash degenerates to kill_mask[0]. Behaviour is otherwise identical.
- Reset or flush mid-hold leaves no residual state other than the stat counters.

Optional Feature:
- Macro PIPE_STAT_EN.
- Defined:
  - stat_bubbles increments on every bubble edge.
  - stat_holds increments on every hold edge.
  - Both are 32-bit and saturate at 0xFFFFFFFF (no wrap).
  - Both are cleared only by rst.
  - Neither counter increments on a flush edge.
- Undefined:
  - stat_bubbles and stat_holds are tied to 0.
  - No counter flops are generated.

Test Plan:
All scenarios use LANES=2, WIDTH=32, CLEAR_DATA=1, KILL_YOUNGER=1.
1. Reset then capture: rst=1 for 2 cycles, then in_valid=2'b11, in_data={32'hBBBB0002,32'hAAAA0001}, no stalls -> next edge out_valid=2'b11, out_data equals in_data, out_bubble=0.
2. Hold: after scenario 1, stall_down=1 and stall_up=1 for 3 cycles with new in_data=0x12345678 on both lanes -> out_data stays {BBBB0002,AAAA0001}, out_held=1. With PIPE_STAT_EN, stat_holds=3.
3. Bubble: stall_up=1, stall_down=0 -> out_valid=2'b00, out_data=0, out_bubble=1. Next cycle with no stalls captures the new bundle and out_bubble=0.
4. Younger kill: in_valid=2'b11, kill_mask=2'b01 -> out_valid=2'b00, both lanes zero. kill_mask=2'b10 -> out_valid=2'b01, lane1 data=0.
5. Flush precedence: stall_down=1 and flush=1 on the same edge -> out_valid=0, out_data=0, out_held=0. stat_holds is unchanged by that edge.
6. Saturation (PIPE_STAT_EN): force stat_bubbles to 0xFFFFFFFE, then apply 3 bubble edges -> stat_bubbles=0xFFFFFFFF, with no wrap to 0.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: N-lane inter-stage pipeline register with per-lane valids,
// kill with optional younger-lane squash, optional payload clearing on
// bubbles/kills, and hold/bubble status flags.
// Optional statistics counters are compiled in when PIPE_STAT_EN is defined;
// otherwise stat_bubbles/stat_holds are tied to zero and no counter flops exist.
module pipe_stage_reg #(
  parameter int unsigned LANES        = 2,
  parameter int unsigned WIDTH        = 128,
  parameter int unsigned CLEAR_DATA   = 1,
  parameter int unsigned KILL_YOUNGER = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     stall_up,
  input  logic                     stall_down,
  input  logic                     flush,
  input  logic [LANES-1:0]         kill_mask,
  input  logic [LANES-1:0]         in_valid,
  input  logic [LANES*WIDTH-1:0]   in_data,
  output logic [LANES-1:0]         out_valid,
  output logic [LANES*WIDTH-1:0]   out_data,
  output logic                     out_bubble,
  output logic                     out_held,
  output logic [31:0]              stat_bubbles,
  output logic [31:0]              stat_holds
);

  typedef enum logic [1:0] {
    ACT_FLUSH   = 2'd0,
    ACT_HOLD    = 2'd1,
    ACT_BUBBLE  = 2'd2,
    ACT_CAPTURE = 2'd3
  } action_e;

  action_e                   action;
  logic [LANES-1:0]          killed;
  logic [LANES-1:0]          valid_q,  valid_d;
  logic [LANES*WIDTH-1:0]    data_q,   data_d;
  logic                      bubble_q, bubble_d;
  logic                      held_q,   held_d;

  // Edge action by priority: flush, then downstream stall, then upstream stall.
  always_comb begin
    action = ACT_CAPTURE;
    if (flush) begin
      action = ACT_FLUSH;
    end else if (stall_down) begin
      action = ACT_HOLD;
    end else if (stall_up) begin
      action = ACT_BUBBLE;
    end
  end

  // Per-lane kill; with younger squash a kill on lane i covers every lane above it.
  always_comb begin
    logic acc;
    acc    = 1'b0;
    killed = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      acc = acc | kill_mask[i];
      if (KILL_YOUNGER != 0) begin
        killed[i] = acc;
      end else begin
        killed[i] = kill_mask[i];
      end
    end
  end

  // Next contents of the stage register for the selected action.
  always_comb begin
    valid_d  = valid_q;
    data_d   = data_q;
    bubble_d = bubble_q;
    held_d   = held_q;
    unique case (action)
      ACT_FLUSH: begin
        valid_d  = '0;
        bubble_d = 1'b0;
        held_d   = 1'b0;
        if (CLEAR_DATA != 0) begin
          data_d = '0;
        end
      end
      ACT_HOLD: begin
        held_d = 1'b1;
      end
      ACT_BUBBLE: begin
        valid_d  = '0;
        bubble_d = 1'b1;
        held_d   = 1'b0;
        if (CLEAR_DATA != 0) begin
          data_d = '0;
        end
      end
      default: begin
        bubble_d = 1'b0;
        held_d   = 1'b0;
        for (int unsigned i = 0; i < LANES; i++) begin
          valid_d[i] = in_valid[i] & ~killed[i];
          if (valid_d[i] || (CLEAR_DATA == 0)) begin
            data_d[i*WIDTH +: WIDTH] = in_data[i*WIDTH +: WIDTH];
          end else begin
            data_d[i*WIDTH +: WIDTH] = '0;
          end
        end
      end
    endcase
  end

  // Stage register; reset clears payload unconditionally, unlike flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= '0;
      data_q   <= '0;
      bubble_q <= 1'b0;
      held_q   <= 1'b0;
    end else begin
      valid_q  <= valid_d;
      data_q   <= data_d;
      bubble_q <= bubble_d;
      held_q   <= held_d;
    end
  end

  assign out_valid  = valid_q;
  assign out_data   = data_q;
  assign out_bubble = bubble_q;
  assign out_held   = held_q;

`ifdef PIPE_STAT_EN
  logic [31:0] stat_bubbles_q, stat_bubbles_d;
  logic [31:0] stat_holds_q,   stat_holds_d;

  // Saturating event counters; flush edges never count because action excludes them.
  always_comb begin
    stat_bubbles_d = stat_bubbles_q;
    stat_holds_d   = stat_holds_q;
    if ((action == ACT_BUBBLE) && (stat_bubbles_q != '1)) begin
      stat_bubbles_d = stat_bubbles_q + 32'd1;
    end
    if ((action == ACT_HOLD) && (stat_holds_q != '1)) begin
      stat_holds_d = stat_holds_q + 32'd1;
    end
  end

  // Counter registers, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_bubbles_q <= '0;
      stat_holds_q   <= '0;
    end else begin
      stat_bubbles_q <= stat_bubbles_d;
      stat_holds_q   <= stat_holds_d;
    end
  end

  assign stat_bubbles = stat_bubbles_q;
  assign stat_holds   = stat_holds_q;
`else
  assign stat_bubbles = '0;
  assign stat_holds   = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg with LANES=2, WIDTH=32, CLEAR_DATA=1,
// KILL_YOUNGER=1. Expected results come from a reference model evaluated
// when stimulus is driven, queued, and compared after the clock edge.
module tb_pipe_stage_reg;

  localparam int unsigned LANES = 2;
  localparam int unsigned WIDTH = 32;

  logic                   clk;
  logic                   rst;
  logic                   stall_up;
  logic                   stall_down;
  logic                   flush;
  logic [LANES-1:0]       kill_mask;
  logic [LANES-1:0]       in_valid;
  logic [LANES*WIDTH-1:0] in_data;
  logic [LANES-1:0]       out_valid;
  logic [LANES*WIDTH-1:0] out_data;
  logic                   out_bubble;
  logic                   out_held;
  logic [31:0]            stat_bubbles;
  logic [31:0]            stat_holds;

  pipe_stage_reg #(
    .LANES       (LANES),
    .WIDTH       (WIDTH),
    .CLEAR_DATA  (1),
    .KILL_YOUNGER(1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .stall_up    (stall_up),
    .stall_down  (stall_down),
    .flush       (flush),
    .kill_mask   (kill_mask),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_bubble  (out_bubble),
    .out_held    (out_held),
    .stat_bubbles(stat_bubbles),
    .stat_holds  (stat_holds)
  );

  typedef struct packed {
    logic [1:0]  v;
    logic [63:0] d;
    logic        b;
    logic        h;
    logic [31:0] sb;
    logic [31:0] sh;
  } obs_t;

  obs_t sb_q[$];
  int   n_vec;
  int   n_err;

  // reference model state
  logic [1:0]  m_v;
  logic [63:0] m_d;
  logic        m_b;
  logic        m_h;
  logic [31:0] m_bub;
  logic [31:0] m_hold;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  function automatic obs_t observe();
    observe = {out_valid, out_data, out_bubble, out_held, stat_bubbles, stat_holds};
  endfunction

  // Apply one edge worth of stimulus, advance the model, queue expectation.
  task automatic drive(input logic r, input logic su, input logic sd, input logic f,
                       input logic [1:0] km, input logic [1:0] iv, input logic [63:0] id);
    obs_t e;
    logic k0, k1;
    rst = r; stall_up = su; stall_down = sd; flush = f;
    kill_mask = km; in_valid = iv; in_data = id;
    if (r || f) begin
      m_v = 2'b00; m_d = 64'h0; m_b = 1'b0; m_h = 1'b0;
      if (r) begin
        m_bub = 32'h0; m_hold = 32'h0;
      end
    end else if (sd) begin
      m_h = 1'b1;
      if (m_hold != 32'hFFFF_FFFF) m_hold = m_hold + 32'd1;
    end else if (su) begin
      m_v = 2'b00; m_d = 64'h0; m_b = 1'b1; m_h = 1'b0;
      if (m_bub != 32'hFFFF_FFFF) m_bub = m_bub + 32'd1;
    end else begin
      k0 = km[0];
      k1 = km[0] | km[1];
      m_v[0] = iv[0] & ~k0;
      m_v[1] = iv[1] & ~k1;
      m_d[31:0]  = m_v[0] ? id[31:0]  : 32'h0;
      m_d[63:32] = m_v[1] ? id[63:32] : 32'h0;
      m_b = 1'b0; m_h = 1'b0;
    end
    e.v = m_v; e.d = m_d; e.b = m_b; e.h = m_h;
`ifdef PIPE_STAT_EN
    e.sb = m_bub; e.sh = m_hold;
`else
    e.sb = 32'h0; e.sh = 32'h0;
`endif
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    obs_t e, o;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b11, 64'hDEAD_BEEF_CAFE_F00D);
      e = sb_q.pop_front(); o = observe(); n_vec++;
      if (o !== e) begin n_err++; $display("FAIL reset[%0d]: got %h required %h", i, o, e); end
    end
    n_vec++;
    if (out_valid !== 2'b00 || out_data !== 64'h0) begin
      n_err++; $display("FAIL reset_const: got v=%b d=%h required v=00 d=0", out_valid, out_data);
    end
  endtask

  task automatic test_capture();
    obs_t e, o;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b11, 64'hBBBB0002_AAAA0001);
    e = sb_q.pop_front(); o = observe(); n_vec++;
    if (o !== e) begin n_err++; $display("FAIL capture: got %h required %h", o, e); end
    n_vec++;
    if (out_valid !== 2'b11 || out_data !== 64'hBBBB0002_AAAA0001 || out_bubble !== 1'b0) begin
      n_err++; $display("FAIL capture_const: got v=%b d=%h b=%b required v=11 d=bbbb0002aaaa0001 b=0",
                        out_valid, out_data, out_bubble);
    end
  endtask

  task automatic test_hold();
    obs_t e, o;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b11, 64'h12345678_12345678);
      e = sb_q.pop_front(); o = observe(); n_vec++;
      if (o !== e) begin n_err++; $display("FAIL hold[%0d]: got %h required %h", i, o, e); end
    end
    n_vec++;
    if (out_data !== 64'hBBBB0002_AAAA0001 || out_held !== 1'b1) begin
      n_err++; $display("FAIL hold_const: got d=%h h=%b required d=bbbb0002aaaa0001 h=1", out_data, out_held);
    end
`ifdef PIPE_STAT_EN
    n_vec++;
    if (stat_holds !== 32'd3) begin
      n_err++; $display("FAIL hold_count: got %0d required 3", stat_holds);
    end
`endif
  endtask

  task automatic test_bubble();
    obs_t e, o;
    drive(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b11, 64'h12345678_12345678);
    e = sb_q.pop_front(); o = observe(); n_vec++;
    if (o !== e) begin n_err++; $display("FAIL bubble: got %h required %h", o, e); end
    n_vec++;
    if (out_valid !== 2'b00 || out_data !== 64'h0 || out_bubble !== 1'b1) begin
      n_err++; $display("FAIL bubble_const: got v=%b d=%h b=%b required v=00 d=0 b=1",
                        out_valid, out_data, out_bubble);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b11, 64'hCCCC0004_DDDD0003);
    e = sb_q.pop_front(); o = observe(); n_vec++;
    if (o !== e) begin n_err++; $display("FAIL bubble_release: got %h required %h", o, e); end
  endtask

  task automatic test_kill();
    obs_t e, o;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b11, 64'h11110002_11110001);
    e = sb_q.pop_front(); o = observe(); n_vec++;
    if (o !== e) begin n_err++; $display("FAIL kill_lane0: got %h required %h", o, e); end
    n_vec++;
    if (out_valid !== 2'b00 || out_data !== 64'h0) begin
      n_err++; $display("FAIL kill_lane0_const: got v=%b d=%h required v=00 d=0", out_valid, out_data);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b11, 64'h22220002_22220001);
    e = sb_q.pop_front(); o = observe(); n_vec++;
    if (o !== e) begin n_err++; $display("FAIL kill_lane1: got %h required %h", o, e); end
    n_vec++;
    if (out_valid !== 2'b01 || out_data !== 64'h00000000_22220001) begin
      n_err++; $display("FAIL kill_lane1_const: got v=%b d=%h required v=01 d=0000000022220001",
                        out_valid, out_data);
    end
  endtask

  task automatic test_flush();
    obs_t e, o;
    logic [31:0] holds_before;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b11, 64'h33330002_33330001);
    e = sb_q.pop_front(); o = observe(); n_vec++;
    if (o !== e) begin n_err++; $display("FAIL flush_setup: got %h required %h", o, e); end
    drive(1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b11, 64'h0);
    e = sb_q.pop_front(); o = observe(); n_vec++;
    if (o !== e) begin n_err++; $display("FAIL flush_hold: got %h required %h", o, e); end
    holds_before = stat_holds;
    drive(1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 2'b11, 64'h44440002_44440001);
    e = sb_q.pop_front(); o = observe(); n_vec++;
    if (o !== e) begin n_err++; $display("FAIL flush: got %h required %h", o, e); end
    n_vec++;
    if (out_valid !== 2'b00 || out_data !== 64'h0 || out_held !== 1'b0 || stat_holds !== holds_before) begin
      n_err++; $display("FAIL flush_const: got v=%b d=%h h=%b holds=%0d required v=00 d=0 h=0 holds=%0d",
                        out_valid, out_data, out_held, stat_holds, holds_before);
    end
  endtask

  task automatic test_back_to_back();
    obs_t e, o;
    logic r, su, sd, f;
    for (int i = 0; i < 60; i++) begin
      r  = ($urandom_range(0, 29) == 0);
      f  = ($urandom_range(0, 9) == 0);
      su = ($urandom_range(0, 3) == 0);
      sd = ($urandom_range(0, 3) == 0);
      drive(r, su, sd, f, 2'($urandom_range(0, 3)) & {2{$urandom_range(0, 1) == 1}},
            2'($urandom_range(0, 3)), {$urandom, $urandom});
      e = sb_q.pop_front(); o = observe(); n_vec++;
      if (o !== e) begin n_err++; $display("FAIL b2b[%0d]: got %h required %h", i, o, e); end
    end
  endtask

`ifdef PIPE_STAT_EN
  task automatic test_saturation();
    obs_t e, o;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 64'h0);
    e = sb_q.pop_front();
    force dut.stat_bubbles_q = 32'hFFFF_FFFE;
    #1;
    release dut.stat_bubbles_q;
    m_bub = 32'hFFFF_FFFE;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b11, 64'h0);
      e = sb_q.pop_front(); o = observe(); n_vec++;
      if (o !== e) begin n_err++; $display("FAIL saturate[%0d]: got %h required %h", i, o, e); end
    end
    n_vec++;
    if (stat_bubbles !== 32'hFFFF_FFFF) begin
      n_err++; $display("FAIL saturate_const: got %h required ffffffff", stat_bubbles);
    end
  endtask
`endif

  initial begin
    n_vec = 0; n_err = 0;
    m_v = '0; m_d = '0; m_b = 1'b0; m_h = 1'b0; m_bub = '0; m_hold = '0;
    rst = 1'b1; stall_up = 1'b0; stall_down = 1'b0; flush = 1'b0;
    kill_mask = '0; in_valid = '0; in_data = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_capture();
    test_hold();
    test_bubble();
    test_kill();
    test_flush();
    test_back_to_back();
`ifdef PIPE_STAT_EN
    test_saturation();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
